// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: opcodes, ALU functs and forward selects.
// Also decides which forward-select port steers rs for a given opcode.
package ex_stage_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_SLTI  = 4'd3;
  localparam logic [3:0] OP_LW    = 4'd4;
  localparam logic [3:0] OP_SW    = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_XOR = 3'b100;
  localparam logic [2:0] FN_SLT = 3'b101;
  localparam logic [2:0] FN_SLL = 3'b110;
  localparam logic [2:0] FN_SRL = 3'b111;

  localparam logic [1:0] FW_REG  = 2'd0;
  localparam logic [1:0] FW_HOT  = 2'd1;
  localparam logic [1:0] FW_COLD = 2'd2;

  // The hazard unit reports I-format ALU sources on its op2 select lane.
  function automatic logic rs_uses_op2_sel(input logic [3:0] opcode);
    return (opcode == OP_ADDI) || (opcode == OP_SLTI);
  endfunction

endpackage

// File: rtl/ex_stage_alu16.sv
// Combinational ALU for the execute stage; op uses the R-format funct encoding.
// Shifts are by one and ignore operand B.
module alu16
  import ex_stage_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [2:0]    i_op,
  output logic [DW-1:0] o_res
);

  logic w_lt;

  assign w_lt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_res = '0;
    case (i_op)
      FN_ADD:  o_res = i_a + i_b;
      FN_SUB:  o_res = i_a - i_b;
      FN_AND:  o_res = i_a & i_b;
      FN_OR:   o_res = i_a | i_b;
      FN_XOR:  o_res = i_a ^ i_b;
      FN_SLT:  o_res = {{(DW-1){1'b0}}, w_lt};
      FN_SLL:  o_res = {i_a[DW-2:0], 1'b0};
      FN_SRL:  o_res = {1'b0, i_a[DW-1:1]};
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
// A taken beq squashes the next instruction that enters EX/MEM.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned IMM_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [15:0]   id_instr,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [1:0]    fwd_op1_sel,
  input  logic [1:0]    fwd_op2_sel,
  input  logic [DW-1:0] fwd_cold_data,
  input  logic          stall,
  input  logic          flush,
  output logic          ex_valid,
  output logic [DW-1:0] ex_alu_res,
  output logic [DW-1:0] ex_store_data,
  output logic [2:0]    ex_wreg,
  output logic          ex_wen,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target
);

  logic          r_valid;
  logic [DW-1:0] r_alu_res;
  logic [DW-1:0] r_store_data;
  logic [2:0]    r_wreg;
  logic          r_wen;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic          r_br_taken;
  logic [DW-1:0] r_br_target;
  logic          r_squash_pending;

  logic [3:0]       w_opcode;
  logic [2:0]       w_rt;
  logic [2:0]       w_rd;
  logic [2:0]       w_funct;
  logic [IMM_W-1:0] w_imm;
  logic [DW-1:0]    w_sext;
  logic [1:0]       w_rs_sel;
  logic [DW-1:0]    w_rs_f;
  logic [DW-1:0]    w_rt_f;
  logic [DW-1:0]    w_alu_b;
  logic [2:0]       w_alu_op;
  logic [DW-1:0]    w_alu_res;
  logic [2:0]       w_wreg;
  logic             w_wen;
  logic             w_mem_rd;
  logic             w_mem_wr;
  logic             w_beq;
  logic             w_issue;
  logic             w_taken;
  logic [DW-1:0]    w_target;
  logic             w_unused_rs;

  assign w_opcode    = id_instr[15:12];
  assign w_rt        = id_instr[8:6];
  assign w_rd        = id_instr[5:3];
  assign w_funct     = id_instr[2:0];
  assign w_imm       = id_instr[IMM_W-1:0];
  assign w_sext      = {{(DW-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  // The rs index is only needed by the hazard unit upstream.
  assign w_unused_rs = ^id_instr[11:9];

  assign w_rs_sel = rs_uses_op2_sel(w_opcode) ? fwd_op2_sel : fwd_op1_sel;

  // Hot source is the EX/MEM register itself, so a stalled stage keeps forwarding it.
  always_comb begin
    case (w_rs_sel)
      FW_HOT:  w_rs_f = r_alu_res;
      FW_COLD: w_rs_f = fwd_cold_data;
      default: w_rs_f = id_rs_data;
    endcase
  end

  always_comb begin
    case (fwd_op2_sel)
      FW_HOT:  w_rt_f = r_alu_res;
      FW_COLD: w_rt_f = fwd_cold_data;
      default: w_rt_f = id_rt_data;
    endcase
  end

  always_comb begin
    w_alu_b  = w_sext;
    w_alu_op = FN_ADD;
    w_wreg   = w_rt;
    w_wen    = 1'b0;
    w_mem_rd = 1'b0;
    w_mem_wr = 1'b0;
    w_beq    = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_alu_b  = w_rt_f;
        w_alu_op = w_funct;
        w_wreg   = w_rd;
        w_wen    = 1'b1;
      end
      OP_ADDI: w_wen = 1'b1;
      OP_SLTI: begin
        w_alu_op = FN_SLT;
        w_wen    = 1'b1;
      end
      OP_LW: begin
        w_mem_rd = 1'b1;
        w_wen    = 1'b1;
      end
      OP_SW:   w_mem_wr = 1'b1;
      OP_BEQ: begin
        w_alu_b  = w_rt_f;
        w_alu_op = FN_SUB;
        w_beq    = 1'b1;
      end
      default: ;
    endcase
  end

  alu16 #(
    .DW (DW)
  ) u_alu (
    .i_a   (w_rs_f),
    .i_b   (w_alu_b),
    .i_op  (w_alu_op),
    .o_res (w_alu_res)
  );

  assign w_issue  = id_valid & ~r_squash_pending;
  assign w_taken  = w_issue & w_beq & (w_rs_f == w_rt_f);
  assign w_target = id_pc + DW'(1) + w_sext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid          <= 1'b0;
      r_alu_res        <= '0;
      r_store_data     <= '0;
      r_wreg           <= '0;
      r_wen            <= 1'b0;
      r_mem_rd         <= 1'b0;
      r_mem_wr         <= 1'b0;
      r_br_taken       <= 1'b0;
      r_br_target      <= '0;
      r_squash_pending <= 1'b0;
    end else if (flush) begin
      r_valid          <= 1'b0;
      r_wen            <= 1'b0;
      r_mem_rd         <= 1'b0;
      r_mem_wr         <= 1'b0;
      r_br_taken       <= 1'b0;
      r_squash_pending <= 1'b0;
    end else if (stall) begin
      r_br_taken <= 1'b0;
    end else begin
      r_valid          <= w_issue;
      r_alu_res        <= w_alu_res;
      r_store_data     <= w_rt_f;
      r_wreg           <= w_wreg;
      r_wen            <= w_issue & w_wen;
      r_mem_rd         <= w_issue & w_mem_rd;
      r_mem_wr         <= w_issue & w_mem_wr;
      r_br_taken       <= w_taken;
      // A squash slot never issues, so this also clears the pending flag.
      r_squash_pending <= w_taken;
      if (w_taken) begin
        r_br_target <= w_target;
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_res    = r_alu_res;
  assign ex_store_data = r_store_data;
  assign ex_wreg       = r_wreg;
  assign ex_wen        = r_wen;
  assign ex_mem_rd     = r_mem_rd;
  assign ex_mem_wr     = r_mem_wr;
  assign branch_taken  = r_br_taken;
  assign branch_target = r_br_target;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected EX/MEM contents per edge,
// a negedge monitor pops and compares them.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_rs_data;
  logic [15:0] id_rt_data;
  logic [1:0]  fwd_op1_sel;
  logic [1:0]  fwd_op2_sel;
  logic [15:0] fwd_cold_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [15:0] ex_alu_res;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_wreg;
  logic        ex_wen;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        branch_taken;
  logic [15:0] branch_target;

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .fwd_op1_sel   (fwd_op1_sel),
    .fwd_op2_sel   (fwd_op2_sel),
    .fwd_cold_data (fwd_cold_data),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_alu_res    (ex_alu_res),
    .ex_store_data (ex_store_data),
    .ex_wreg       (ex_wreg),
    .ex_wen        (ex_wen),
    .ex_mem_rd     (ex_mem_rd),
    .ex_mem_wr     (ex_mem_wr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always #5 clk = ~clk;

  // Mask bits select which field groups a row checks.
  localparam logic [4:0] M_CTL = 5'b00001;
  localparam logic [4:0] M_ALU = 5'b00010;
  localparam logic [4:0] M_SD  = 5'b00100;
  localparam logic [4:0] M_WR  = 5'b01000;
  localparam logic [4:0] M_TGT = 5'b10000;
  localparam logic [4:0] M_ALL = 5'b11111;

  typedef struct {
    int          tag;
    logic [4:0]  mask;
    logic        v;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [2:0]  wreg;
    logic        wen;
    logic        mrd;
    logic        mwr;
    logic        bt;
    logic [15:0] tgt;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t  e;
      string nm;
      e  = q.pop_front();
      nm = nq.pop_front();
      if (e.mask[0]) begin
        chk({nm, ".valid"}, {15'b0, ex_valid}, {15'b0, e.v});
        chk({nm, ".wen"}, {15'b0, ex_wen}, {15'b0, e.wen});
        chk({nm, ".mem_rd"}, {15'b0, ex_mem_rd}, {15'b0, e.mrd});
        chk({nm, ".mem_wr"}, {15'b0, ex_mem_wr}, {15'b0, e.mwr});
        chk({nm, ".br_taken"}, {15'b0, branch_taken}, {15'b0, e.bt});
      end
      if (e.mask[1]) chk({nm, ".alu_res"}, ex_alu_res, e.alu);
      if (e.mask[2]) chk({nm, ".store_data"}, ex_store_data, e.sd);
      if (e.mask[3]) chk({nm, ".wreg"}, {13'b0, ex_wreg}, {13'b0, e.wreg});
      if (e.mask[4]) chk({nm, ".br_target"}, branch_target, e.tgt);
    end
  end

  function automatic logic [15:0] rtyp(input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [2:0] rd, input logic [2:0] fn);
    return {OP_RTYPE, rs, rt, rd, fn};
  endfunction

  function automatic logic [15:0] ityp(input logic [3:0] op, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [5:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drv(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                     input logic [15:0] rs, input logic [15:0] rt, input logic [1:0] s1,
                     input logic [1:0] s2, input logic [15:0] cold);
    id_valid      = v;
    id_instr      = ins;
    id_pc         = pc;
    id_rs_data    = rs;
    id_rt_data    = rt;
    fwd_op1_sel   = s1;
    fwd_op2_sel   = s2;
    fwd_cold_data = cold;
  endtask

  // Push the expected EX/MEM contents after the coming edge, then advance to the negedge.
  task automatic go(input string nm, input logic [4:0] mask, input logic v,
                    input logic [15:0] alu, input logic [15:0] sd, input logic [2:0] wreg,
                    input logic wen, input logic mrd, input logic mwr, input logic bt,
                    input logic [15:0] tgt);
    exp_t e;
    e.tag  = cyc + 1;
    e.mask = mask;
    e.v    = v;
    e.alu  = alu;
    e.sd   = sd;
    e.wreg = wreg;
    e.wen  = wen;
    e.mrd  = mrd;
    e.mwr  = mwr;
    e.bt   = bt;
    e.tgt  = tgt;
    q.push_back(e);
    nq.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drv(1, rtyp(1, 2, 3, FN_ADD), 16'h0, 16'd5, 16'd7, FW_REG, FW_REG, 16'h0);
    go("rst0", M_ALL, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    go("rst1", M_ALL, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    rst = 1'b0;

    go("add", M_CTL | M_ALU | M_WR | M_TGT, 1, 16'd12, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(3, 1, 4, FN_ADD), 16'h0, 16'd0, 16'd5, FW_HOT, FW_REG, 16'h0);
    go("add_hot", M_CTL | M_ALU | M_WR, 1, 16'd17, 16'h0, 3'd4, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(1, 2, 5, FN_SUB), 16'h0, 16'd5, 16'd7, FW_REG, FW_REG, 16'h0);
    go("sub", M_CTL | M_ALU | M_WR, 1, 16'hFFFE, 16'h0, 3'd5, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(1, 2, 6, FN_SLT), 16'h0, 16'hFFFF, 16'd1, FW_REG, FW_REG, 16'h0);
    go("slt_neg", M_CTL | M_ALU, 1, 16'd1, 16'h0, 3'd6, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(1, 2, 6, FN_SLT), 16'h0, 16'd1, 16'hFFFF, FW_REG, FW_REG, 16'h0);
    go("slt_pos", M_CTL | M_ALU, 1, 16'd0, 16'h0, 3'd6, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(1, 2, 6, FN_SLL), 16'h0, 16'h8001, 16'd0, FW_REG, FW_REG, 16'h0);
    go("sll", M_ALU, 1, 16'h0002, 16'h0, 3'd6, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(1, 2, 6, FN_SRL), 16'h0, 16'h8001, 16'd0, FW_REG, FW_REG, 16'h0);
    go("srl", M_ALU, 1, 16'h4000, 16'h0, 3'd6, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(1, 2, 6, FN_XOR), 16'h0, 16'h0F0F, 16'h00FF, FW_REG, FW_REG, 16'h0);
    go("xor", M_ALU, 1, 16'h0FF0, 16'h0, 3'd6, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(1, 2, 6, FN_AND), 16'h0, 16'h0F0F, 16'h00FF, FW_REG, FW_REG, 16'h0);
    go("and", M_ALU, 1, 16'h000F, 16'h0, 3'd6, 1, 0, 0, 0, 16'h0);
    drv(1, rtyp(1, 2, 6, FN_OR), 16'h0, 16'h0F0F, 16'h00FF, FW_REG, FW_REG, 16'h0);
    go("or", M_ALU, 1, 16'h0FFF, 16'h0, 3'd6, 1, 0, 0, 0, 16'h0);

    drv(1, ityp(OP_ADDI, 2, 5, 6'h3F), 16'h0, 16'h1234, 16'h0, FW_REG, FW_COLD, 16'h00F0);
    go("addi_cold", M_CTL | M_ALU | M_WR, 1, 16'h00EF, 16'h0, 3'd5, 1, 0, 0, 0, 16'h0);
    drv(1, ityp(OP_SLTI, 4, 2, 6'h3E), 16'h0, 16'hFFFD, 16'h0, FW_REG, FW_REG, 16'h0);
    go("slti", M_CTL | M_ALU | M_WR, 1, 16'd1, 16'h0, 3'd2, 1, 0, 0, 0, 16'h0);
    drv(1, ityp(OP_LW, 1, 6, 6'h02), 16'h0, 16'h0200, 16'h0, FW_REG, FW_REG, 16'h0);
    go("lw", M_CTL | M_ALU | M_WR, 1, 16'h0202, 16'h0, 3'd6, 1, 1, 0, 0, 16'h0);
    drv(1, ityp(OP_ADDI, 1, 2, 6'h3F), 16'h0, 16'hBEF0, 16'h0, FW_REG, FW_REG, 16'h0);
    go("addi_beef", M_ALU, 1, 16'hBEEF, 16'h0, 3'd2, 1, 0, 0, 0, 16'h0);
    drv(1, ityp(OP_SW, 1, 2, 6'h04), 16'h0, 16'h0100, 16'h0, FW_REG, FW_HOT, 16'h0);
    go("sw", M_CTL | M_ALU | M_SD, 1, 16'h0104, 16'hBEEF, 3'd2, 0, 0, 1, 0, 16'h0);

    drv(1, ityp(OP_BEQ, 1, 2, 6'h3D), 16'h0010, 16'd9, 16'd9, FW_REG, FW_REG, 16'h0);
    go("beq_t", M_CTL | M_ALU | M_TGT, 1, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1, 16'h000E);
    drv(1, ityp(OP_ADDI, 1, 3, 6'h01), 16'h0, 16'd3, 16'h0, FW_REG, FW_REG, 16'h0);
    go("squash", M_CTL | M_TGT, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h000E);
    go("after_sq", M_CTL | M_ALU | M_WR, 1, 16'd4, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0);
    drv(1, ityp(OP_BEQ, 1, 2, 6'h02), 16'h0020, 16'd9, 16'd8, FW_REG, FW_REG, 16'h0);
    go("beq_nt", M_CTL | M_ALU | M_TGT, 1, 16'd1, 16'h0, 3'd0, 0, 0, 0, 0, 16'h000E);
    drv(1, ityp(OP_ADDI, 1, 3, 6'h01), 16'h0, 16'd10, 16'h0, FW_REG, FW_REG, 16'h0);
    go("no_sq", M_CTL | M_ALU, 1, 16'd11, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0);
    drv(1, ityp(OP_BEQ, 1, 2, 6'h00), 16'hFFFF, 16'd0, 16'd0, FW_REG, FW_REG, 16'h0);
    go("beq_wrap", M_CTL | M_TGT, 1, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1, 16'h0000);
    drv(1, ityp(OP_ADDI, 1, 3, 6'h01), 16'h0, 16'd10, 16'h0, FW_REG, FW_REG, 16'h0);
    go("squash2", M_CTL, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);

    drv(1, ityp(OP_ADDI, 1, 3, 6'h01), 16'h0, 16'h0040, 16'h0055, FW_REG, FW_REG, 16'h0);
    go("pre_stall", M_ALL, 1, 16'h0041, 16'h0055, 3'd3, 1, 0, 0, 0, 16'h0);
    stall = 1'b1;
    drv(1, ityp(OP_LW, 5, 7, 6'h02), 16'h0, 16'h9999, 16'h7777, FW_REG, FW_REG, 16'h0);
    for (int i = 0; i < 3; i++) begin
      go($sformatf("stall%0d", i), M_ALL, 1, 16'h0041, 16'h0055, 3'd3, 1, 0, 0, 0, 16'h0);
    end
    stall = 1'b0;
    drv(1, rtyp(3, 1, 4, FN_ADD), 16'h0, 16'd0, 16'd1, FW_HOT, FW_REG, 16'h0);
    go("hot_after_stall", M_CTL | M_ALU | M_WR, 1, 16'h0042, 16'h0, 3'd4, 1, 0, 0, 0, 16'h0);

    drv(1, ityp(OP_BEQ, 1, 2, 6'h05), 16'h0100, 16'd2, 16'd2, FW_REG, FW_REG, 16'h0);
    go("beq_t2", M_CTL | M_TGT, 1, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1, 16'h0106);
    stall = 1'b1;
    drv(1, ityp(OP_ADDI, 1, 3, 6'h01), 16'h0, 16'd3, 16'h0, FW_REG, FW_REG, 16'h0);
    go("stall_bt", M_CTL | M_ALU | M_TGT, 1, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0106);
    stall = 1'b0;
    go("sq_held", M_CTL, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    go("after_sq2", M_CTL | M_ALU, 1, 16'd4, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0);

    stall = 1'b1;
    flush = 1'b1;
    go("flush_stall", M_CTL, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    stall = 1'b0;
    flush = 1'b0;
    drv(1, ityp(OP_ADDI, 1, 3, 6'h01), 16'h0, 16'd7, 16'h0, FW_REG, FW_REG, 16'h0);
    go("post_flush", M_CTL | M_ALU, 1, 16'd8, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0);

    flush = 1'b1;
    drv(1, ityp(OP_BEQ, 1, 2, 6'h05), 16'h0200, 16'd1, 16'd1, FW_REG, FW_REG, 16'h0);
    go("beq_flushed", M_CTL | M_TGT, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0106);
    flush = 1'b0;
    drv(1, ityp(OP_ADDI, 1, 3, 6'h01), 16'h0, 16'd7, 16'h0, FW_REG, FW_REG, 16'h0);
    go("no_sq_after_fl", M_CTL | M_ALU, 1, 16'd8, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0);

    drv(1, ityp(OP_BEQ, 1, 2, 6'h01), 16'h0300, 16'd4, 16'd4, FW_REG, FW_REG, 16'h0);
    go("beq_t3", M_CTL | M_TGT, 1, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1, 16'h0302);
    stall = 1'b1;
    drv(1, ityp(OP_ADDI, 1, 3, 6'h01), 16'h0, 16'd7, 16'h0, FW_REG, FW_REG, 16'h0);
    go("stall_bt3", M_CTL, 1, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    stall = 1'b0;
    flush = 1'b1;
    go("flush_sq", M_CTL, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    flush = 1'b0;
    go("sq_cleared", M_CTL | M_ALU, 1, 16'd8, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0);

    drv(1, {4'd2, 12'h0C5}, 16'h0, 16'd7, 16'd7, FW_REG, FW_REG, 16'h0);
    go("nop_op", M_CTL, 1, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    drv(0, ityp(OP_LW, 1, 3, 6'h01), 16'h0, 16'd7, 16'h0, FW_REG, FW_REG, 16'h0);
    go("invalid", M_CTL, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    drv(1, ityp(OP_LW, 1, 3, 6'h01), 16'h0, 16'd7, 16'h0, FW_REG, FW_REG, 16'h0);
    rst = 1'b1;
    go("rst_late", M_ALL, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 16'h0);
    rst = 1'b0;

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipeline. It sits directly downstream of the hazard/forwarding unit and consumes that unit's operand-select outputs.
- Picks each ALU operand from three sources: register file, hot forward (own EX/MEM result) or cold forward (MEM/WB result).
- Executes R/I-format ALU ops, lw/sw address generation and beq resolution.
- Registers everything into the EX/MEM pipeline register, with stall, flush and taken-branch squash.

Parameters:
- DW, 16, datapath width.
- IMM_W, 6, immediate field width (instr[5:0]), sign-extended to DW.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_valid  in  1  ID/EX holds a valid instruction
- id_instr  in  16  instruction; opcode[15:12] rs[11:9] rt[8:6] rd[5:3] funct[2:0] imm[5:0]
- id_pc  in  16  PC of id_instr
- id_rs_data  in  16  register-file value of rs
- id_rt_data  in  16  register-file value of rt
- fwd_op1_sel  in  2  0=regfile, 1=hot, 2=cold, 3=regfile
- fwd_op2_sel  in  2  same encoding
- fwd_cold_data  in  16  MEM/WB result
- stall  in  1  hold EX/MEM
- flush  in  1  squash instruction entering EX/MEM
- ex_valid  out  1  EX/MEM valid
- ex_alu_res  out  16  ALU result / memory address
- ex_store_data  out  16  forwarded rt for sw
- ex_wreg  out  3  destination register
- ex_wen  out  1  regfile write enable
- ex_mem_rd  out  1  lw
- ex_mem_wr  out  1  sw
- branch_taken  out  1  one-cycle pulse, beq taken
- branch_target  out  16  id_pc + 1 + sext(imm)

Behaviour:
- Reset is rst, synchronous, active-high, on clock clk. At reset every output and internal register is 0, including squash_pending.
- Operand muxes are combinational on id_*:
  - rs_f = sel(fwd_op1_sel, id_rs_data) for opcodes 0, 4, 5, 6.
  - For opcodes 1 and 3, rs is forwarded through the fwd_op2_sel path.
  - rt_f = sel(fwd_op2_sel, id_rt_data).
  - Hot source = current ex_alu_res register. Cold source = fwd_cold_data.
- Opcode 0 (R-format): A=rs_f, B=rt_f. funct 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 1/0), 110 sll by 1, 111 srl by 1. wreg=rd, wen=1.
- Opcode 1 (addi): rs_f + sext(imm). Opcode 3 (slti): signed rs_f < sext(imm). Both: wreg=rt, wen=1.
- Opcode 4 (lw): addr = rs_f + sext(imm), mem_rd=1, wreg=rt, wen=1.
- Opcode 5 (sw): addr = rs_f + sext(imm), store_data = rt_f, mem_wr=1, wen=0.
- Opcode 6 (beq): taken = (rs_f == rt_f). wen=0, no memory access. ex_alu_res = rs_f - rt_f.
- Other opcodes: NOP; valid propagates, all enables 0.
- Arithmetic is modulo 2^16 with no overflow trap. branch_target is computed mod 2^16 and may wrap.
- Latency: 1 cycle. Fields present at edge N appear on ex_* after edge N.
- Precedence each edge: rst > flush > stall > squash > normal.
  - flush=1: ex_valid<=0, ex_wen/ex_mem_rd/ex_mem_wr/branch_taken<=0. Data fields are don't-care and hold.
  - stall=1 (no flush): all EX/MEM registers hold. branch_taken<=0. squash_pending holds.
  - Normal: ex_valid <= id_valid & ~squash_pending. Enables and branch_taken are gated by that valid.
- squash state: squash_pending<=1 on the edge that sets branch_taken. It clears on the next non-stalled edge, which registers a bubble (ex_valid=0).
- Flush or rst clears squash_pending.
- branch_taken is high for exactly one cycle per taken beq. branch_target is registered alongside it and held otherwise.
- Hot forwarding during stall returns the held ex_alu_res, even when ex_valid=0.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE=0, OP_ADDI=1, OP_SLTI=3, OP_LW=4, OP_SW=5, OP_BEQ=6
  - funct constants
  - forward-select constants FW_REG=0, FW_HOT=1, FW_COLD=2
- One natural sub-module, alu16: combinational, A, B and 3-bit op in, 16-bit result out.

Test Plan:
- reset: rst=1 for 2 cycles with id_valid=1 -> all outputs 0. First ALU result appears one cycle after rst falls.
- R add, hot forward:
  - Stimulus: add r3=r1+r2 (rs=5, rt=7), then add r4=r3+r1 with op1_sel=1, id_rs_data=0.
  - Required: ex_alu_res 12, then 17.
- Cold forward and addi:
  - Stimulus: addi with rs via op2_sel=2, fwd_cold_data=0x00F0, imm=6'b111111.
  - Required: ex_alu_res 0x00EF, ex_wreg=rt.
- lw/sw:
  - Stimulus: sw rs=0x0100, imm=4, rt forwarded hot = 0xBEEF.
  - Required: ex_alu_res 0x0104, ex_store_data 0xBEEF, mem_wr=1, wen=0.
- beq taken with squash:
  - Stimulus: beq with rs_f=rt_f=9, pc=0x0010, imm=-3, followed by valid addi.
  - Required: branch_taken pulse, target 0x000E; the addi slot yields ex_valid=0. Same test with rs≠rt -> no pulse, no squash.
- stall/flush collision:
  - Stall 3 cycles mid-stream -> outputs frozen.
  - flush and stall asserted together -> ex_valid=0 next cycle.
  - Taken beq then flush in the same cycle -> squash_pending cleared.
